// File: rtl/shift32_r_iter_pkg.sv
// Shared widths and FSM encoding for the iterative right shifter.
// Optional SRA support is enabled by the SHIFT32_R_ARITH_EN macro.
package shift32_r_iter_pkg;

    localparam int SR_DATA_WIDTH  = 32;
    localparam int SR_SHAMT_WIDTH = 5;

    // 2'b11 is unused; the FSM treats it as illegal and falls back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift32_r_iter_if.sv
// Start/done request bus between the ALU operand stage and the shifter.
// The arith signal exists only when SHIFT32_R_ARITH_EN is defined.
interface shift32_r_iter_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
);
    logic                   start;
    logic [DATA_WIDTH-1:0]  D;
    logic [SHAMT_WIDTH-1:0] S;
`ifdef SHIFT32_R_ARITH_EN
    logic                   arith;
`endif
    logic                   busy;
    logic                   done;
    logic [DATA_WIDTH-1:0]  Y;

`ifdef SHIFT32_R_ARITH_EN
    modport master (output start, D, S, arith, input busy, done, Y);
    modport slave  (input start, D, S, arith, output busy, done, Y);
`else
    modport master (output start, D, S, input busy, done, Y);
    modport slave  (input start, D, S, output busy, done, Y);
`endif

endinterface

// File: rtl/shift32_r_iter_shift_r_stage.sv
// One row of 2:1 muxes: passes din through or shifts it right by 2**STAGE,
// filling vacated MSBs with the fill bit.
module shift32_r_iter_shift_r_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGE      = 0
) (
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  fill,
    input  logic                  sel,
    output logic [DATA_WIDTH-1:0] dout
);
    localparam int DIST = 1 << STAGE;

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
            if (gi + DIST < DATA_WIDTH) begin : g_src
                assign dout[gi] = sel ? din[gi + DIST] : din[gi];
            end else begin : g_fill
                assign dout[gi] = sel ? fill : din[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/shift32_r_iter.sv
// Multi-cycle logarithmic right shifter: one shift-amount bit per clock.
// Define SHIFT32_R_ARITH_EN to add the arith input (sign-filling SRA).
module shift32_r_iter
    import shift32_r_iter_pkg::*;
#(
    parameter int DATA_WIDTH  = SR_DATA_WIDTH,
    parameter int SHAMT_WIDTH = SR_SHAMT_WIDTH
) (
    input  logic            CLK,
    input  logic            RST,
    shift32_r_iter_if.slave bus
);
    state_t                 state_reg;
    logic [DATA_WIDTH-1:0]  acc_reg;
    logic [DATA_WIDTH-1:0]  acc_next;
    logic [DATA_WIDTH-1:0]  y_reg;
    logic [SHAMT_WIDTH-1:0] amt_reg;
    logic [SHAMT_WIDTH-1:0] k_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   fill;
    logic                   last_stage;

`ifdef SHIFT32_R_ARITH_EN
    // Sign is captured once; every SRA stage fills with the original MSB.
    logic fill_reg;
    assign fill = fill_reg;
`else
    assign fill = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] stage_out [SHAMT_WIDTH];

    generate
        for (genvar gi = 0; gi < SHAMT_WIDTH; gi++) begin : g_stage
            shift32_r_iter_shift_r_stage #(
                .DATA_WIDTH(DATA_WIDTH),
                .STAGE     (gi)
            ) u_stage (
                .din (acc_reg),
                .fill(fill),
                .sel (amt_reg[gi]),
                .dout(stage_out[gi])
            );
        end
    endgenerate

    always_comb begin
        acc_next = acc_reg;
        for (int i = 0; i < SHAMT_WIDTH; i++) begin
            if (k_reg == SHAMT_WIDTH'(i)) acc_next = stage_out[i];
        end
    end

    assign last_stage = (k_reg == SHAMT_WIDTH'(SHAMT_WIDTH - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            amt_reg   <= '0;
            k_reg     <= '0;
            y_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef SHIFT32_R_ARITH_EN
            fill_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        acc_reg   <= bus.D;
                        amt_reg   <= bus.S;
                        k_reg     <= '0;
`ifdef SHIFT32_R_ARITH_EN
                        fill_reg  <= bus.arith & bus.D[DATA_WIDTH-1];
`endif
                        busy_reg  <= 1'b1;
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc_reg <= acc_next;
                    k_reg   <= k_reg + 1'b1;
                    if (last_stage) begin
                        y_reg     <= acc_next;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.Y    = y_reg;

endmodule
